// File: rtl/precount_pkg.sv
// Shared types and the expected-result rule for the preload counter sequencer.
package precount_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_READ,
    S_RESP
  } state_t;

  // Full-width result; callers keep the low WIDTH bits, which gives mod 2^WIDTH.
  function automatic logic [31:0] expected_count(input logic [31:0] start,
                                                 input logic [31:0] steps,
                                                 input logic        up);
    return up ? (start + steps) : (start - steps);
  endfunction

endpackage

// File: rtl/precount_seq.sv
// Turns one {start, dir, steps} command into load / count / read of the preload counter.
// Latency: response valid steps+RD_WAIT+3 cycles after acceptance.
// Backpressure: response held in RESP until rsp_ready; commands outside IDLE are dropped.
module precount_seq
  import precount_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int RD_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_up,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [7:0]       cmd_steps,
  output logic [WIDTH-1:0] ctr_din,
  output logic             ctr_load,
  output logic             ctr_up,
  output logic             ctr_enb,
  output logic             ctr_rdb,
  input  logic             ctr_carry,
  input  logic [WIDTH-1:0] ctr_dout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_mismatch
);

  localparam logic [1:0] RDW = 2'(RD_WAIT);

  state_t     state, state_nxt;
  logic [7:0] steps_q;
  logic [7:0] step_cnt, step_nxt;
  logic [1:0] wait_cnt, wait_nxt;
  logic       accept;
  logic       sample;
  logic [31:0] exp_full;
  logic        unused_exp_hi;

  // ctr_din / ctr_up double as the registered start value and direction.
  assign exp_full      = expected_count(32'(ctr_din), 32'(steps_q), ctr_up);
  assign unused_exp_hi = ^exp_full[31:WIDTH];

  assign accept = cmd_valid && cmd_ready;
  assign sample = (state == S_READ) && (wait_cnt == RDW);

  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    wait_nxt  = wait_cnt;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        wait_nxt = '0;
        if (steps_q == 8'd0) begin
          state_nxt = S_READ;
        end else begin
          state_nxt = S_COUNT;
          step_nxt  = steps_q;
        end
      end
      S_COUNT: begin
        step_nxt = step_cnt - 8'd1;
        wait_nxt = '0;
        if (step_cnt == 8'd1) state_nxt = S_READ;
      end
      S_READ: begin
        wait_nxt = wait_cnt + 2'd1;
        if (wait_cnt == RDW) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are flops decoded from the next state, so nothing is combinational.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      steps_q      <= '0;
      step_cnt     <= '0;
      wait_cnt     <= '0;
      cmd_ready    <= 1'b1;
      ctr_din      <= '0;
      ctr_load     <= 1'b0;
      ctr_up       <= 1'b1;
      ctr_enb      <= 1'b1;
      ctr_rdb      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_carry    <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_cnt  <= step_nxt;
      wait_cnt  <= wait_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      ctr_load  <= (state_nxt == S_LOAD);
      ctr_enb   <= (state_nxt != S_COUNT);
      ctr_rdb   <= (state_nxt == S_READ);
      rsp_valid <= (state_nxt == S_RESP);

      if (accept) begin
        ctr_din   <= cmd_start;
        ctr_up    <= cmd_up;
        steps_q   <= cmd_steps;
        rsp_carry <= 1'b0;
      end else if ((state == S_COUNT || state == S_READ) && ctr_carry) begin
        rsp_carry <= 1'b1;
      end

      if (sample) begin
        rsp_data     <= ctr_dout;
        rsp_mismatch <= (ctr_dout != exp_full[WIDTH-1:0]);
      end
    end
  end

endmodule
